// File: rtl/inst_resp_recv_pkg.sv
// Shared bus widths and sizing for the instruction response receiver.
package inst_resp_recv_pkg;

  localparam int PC_BUS_W    = 32;
  localparam int DATA_BUS_W  = 64;
  localparam int FETCH_DEPTH = 4;

  // Reset is active-high on this path, even though the port keeps the rst_n name.
  localparam logic RST_ENABLE = 1'b1;

  // Pointer width including the wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/inst_resp_recv_ptr_ctrl.sv
// Pointer and credit bookkeeping for the fetch response buffer.
import inst_resp_recv_pkg::*;

module inst_resp_ptr_ctrl #(
  parameter  int DEPTH = FETCH_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          excep_flush_i,
  input  logic          req_fire_i,
  input  logic          data_ok_i,
  input  logic          pop_i,
  output logic [AW-1:0] alloc_idx,
  output logic [AW-1:0] fill_idx,
  output logic [AW-1:0] head_idx,
  output logic          alloc_we,
  output logic          fill_we,
  output logic          occ_nz,
  output logic          req_allow_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  // Wide enough for discard + unfilled + one request without overflow.
  localparam int SW = CW + 2;

  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] head_ptr;
  logic [CW-1:0] discard_cnt;

  logic [PW-1:0] occ;
  logic [PW-1:0] unfilled;
  logic [SW-1:0] flush_sum;
  logic [SW-1:0] flush_disc;
  logic          drop;
  logic          pop_en;

  assign occ      = alloc_ptr - head_ptr;
  assign unfilled = alloc_ptr - fill_ptr;

  assign alloc_idx = alloc_ptr[AW-1:0];
  assign fill_idx  = fill_ptr[AW-1:0];
  assign head_idx  = head_ptr[AW-1:0];
  assign occ_nz    = (occ != '0);

  // Credit check uses registers only, so it never loops back through the bus.
  assign req_allow_o = (SW'(occ) + SW'(discard_cnt)) < SW'(DEPTH);

  // Responses still owed after a flush cycle; a same-cycle response pays one off.
  assign flush_sum  = SW'(discard_cnt) + SW'(unfilled) + SW'(req_fire_i);
  assign flush_disc = (flush_sum > SW'(data_ok_i)) ? (flush_sum - SW'(data_ok_i)) : '0;

  assign drop     = data_ok_i && (discard_cnt != '0);
  assign alloc_we = !excep_flush_i && req_fire_i;
  assign fill_we  = !excep_flush_i && data_ok_i && (discard_cnt == '0) && (unfilled != '0);
  assign pop_en   = !excep_flush_i && pop_i;

  // Pointer and discard counter update; flush collapses the buffer onto alloc_ptr.
  always_ff @(posedge clk) begin
    if (rst_n == RST_ENABLE) begin
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      discard_cnt <= '0;
    end else if (excep_flush_i) begin
      fill_ptr    <= alloc_ptr;
      head_ptr    <= alloc_ptr;
      discard_cnt <= CW'(flush_disc);
    end else begin
      if (alloc_we) alloc_ptr   <= alloc_ptr + 1'b1;
      if (fill_we)  fill_ptr    <= fill_ptr + 1'b1;
      if (pop_en)   head_ptr    <= head_ptr + 1'b1;
      if (drop)     discard_cnt <= discard_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/inst_resp_recv.sv
// Fetch response receiver: pairs in-order bus responses with their request PCs
// and hands {pc, packet} to IF through a valid/allowin handshake.
import inst_resp_recv_pkg::*;

module inst_resp_recv #(
  parameter int DEPTH  = FETCH_DEPTH,
  parameter int PC_W   = PC_BUS_W,
  parameter int DATA_W = DATA_BUS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              excep_flush_i,
  input  logic              req_fire_i,
  input  logic [PC_W-1:0]   req_pc_i,
  output logic              req_allow_o,
  input  logic              data_ok_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              inst_valid_o,
  output logic [PC_W-1:0]   inst_pc_o,
  output logic [DATA_W-1:0] inst_data_o,
  input  logic              if_allowin_i
);

  localparam int AW = $clog2(DEPTH);

  logic [PC_W-1:0]   pc_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  filled_q;

  logic [AW-1:0] alloc_idx;
  logic [AW-1:0] fill_idx;
  logic [AW-1:0] head_idx;
  logic          alloc_we;
  logic          fill_we;
  logic          occ_nz;
  logic          pop;

  assign pop = inst_valid_o & if_allowin_i;

  inst_resp_ptr_ctrl #(
    .DEPTH(DEPTH)
  ) u_ptr (
    .clk           (clk),
    .rst_n         (rst_n),
    .excep_flush_i (excep_flush_i),
    .req_fire_i    (req_fire_i),
    .data_ok_i     (data_ok_i),
    .pop_i         (pop),
    .alloc_idx     (alloc_idx),
    .fill_idx      (fill_idx),
    .head_idx      (head_idx),
    .alloc_we      (alloc_we),
    .fill_we       (fill_we),
    .occ_nz        (occ_nz),
    .req_allow_o   (req_allow_o)
  );

  // Entry storage: PC written on allocate, data and filled flag on response.
  always_ff @(posedge clk) begin
    if (rst_n == RST_ENABLE) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
      filled_q <= '0;
    end else begin
      if (alloc_we) pc_q[alloc_idx] <= req_pc_i;
      if (fill_we)  data_q[fill_idx] <= rdata_i;
      if (excep_flush_i) begin
        filled_q <= '0;
      end else begin
        // alloc and fill never target the same slot in one cycle
        if (alloc_we) filled_q[alloc_idx] <= 1'b0;
        if (fill_we)  filled_q[fill_idx]  <= 1'b1;
      end
    end
  end

  // Head entry drives IF straight from registers; stale filled bits of popped
  // slots are masked by the occupancy check.
  always_comb begin
    inst_valid_o = occ_nz & filled_q[head_idx];
    inst_pc_o    = pc_q[head_idx];
    inst_data_o  = data_q[head_idx];
  end

endmodule

// File: tb/tb_inst_resp_recv.sv
// Bench for inst_resp_recv: directed scenarios plus random legal traffic,
// checked every cycle against a queue-based model.
module tb_inst_resp_recv;

  localparam int DEPTH  = 4;
  localparam int PC_W   = 32;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              excep_flush_i = 1'b0;
  logic              req_fire_i = 1'b0;
  logic [PC_W-1:0]   req_pc_i = '0;
  logic              req_allow_o;
  logic              data_ok_i = 1'b0;
  logic [DATA_W-1:0] rdata_i = '0;
  logic              inst_valid_o;
  logic [PC_W-1:0]   inst_pc_o;
  logic [DATA_W-1:0] inst_data_o;
  logic              if_allowin_i = 1'b0;

  always #5 clk = ~clk;

  inst_resp_recv #(
    .DEPTH(DEPTH), .PC_W(PC_W), .DATA_W(DATA_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .excep_flush_i (excep_flush_i),
    .req_fire_i    (req_fire_i),
    .req_pc_i      (req_pc_i),
    .req_allow_o   (req_allow_o),
    .data_ok_i     (data_ok_i),
    .rdata_i       (rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_pc_o     (inst_pc_o),
    .inst_data_o   (inst_data_o),
    .if_allowin_i  (if_allowin_i)
  );

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
    bit                filled;
  } ent_t;

  ent_t mq[$];
  int   m_disc = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_valid();
    return (mq.size() > 0) && mq[0].filled;
  endfunction

  function automatic int m_unfilled();
    int n = 0;
    foreach (mq[i]) if (!mq[i].filled) n++;
    return n;
  endfunction

  function automatic bit m_allow();
    return (mq.size() + m_disc) < DEPTH;
  endfunction

  task automatic m_update(input bit rst, input bit flush, input bit fire, input logic [PC_W-1:0] pc,
                          input bit dok, input logic [DATA_W-1:0] data, input bit allowin);
    ent_t e;
    bit   p;
    int   n;
    if (rst) begin
      mq.delete();
      m_disc = 0;
    end else if (flush) begin
      n = m_disc + m_unfilled() + int'(fire) - int'(dok);
      m_disc = (n < 0) ? 0 : n;
      mq.delete();
    end else begin
      p = m_valid() && allowin;
      if (dok) begin
        if (m_disc > 0) begin
          m_disc--;
        end else begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].filled) begin
              mq[i].data   = data;
              mq[i].filled = 1'b1;
              break;
            end
          end
        end
      end
      if (p) void'(mq.pop_front());
      if (fire) begin
        e.pc = pc; e.data = '0; e.filled = 1'b0;
        mq.push_back(e);
      end
    end
  endtask

  task automatic compare_outputs();
    chk("allow", req_allow_o, m_allow());
    chk("valid", inst_valid_o, m_valid());
    if (m_valid()) begin
      chk("pc", inst_pc_o, mq[0].pc);
      chk("data", inst_data_o, mq[0].data);
    end
  endtask

  // Called at a negedge; returns at the following negedge after checking.
  task automatic step(input bit rst, input bit flush, input bit fire, input logic [PC_W-1:0] pc,
                      input bit dok, input logic [DATA_W-1:0] data, input bit allowin);
    rst_n = rst; excep_flush_i = flush; req_fire_i = fire; req_pc_i = pc;
    data_ok_i = dok; rdata_i = data; if_allowin_i = allowin;
    m_update(rst, flush, fire, pc, dok, data, allowin);
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle(input bit allowin);
    step(0, 0, 0, '0, 0, '0, allowin);
  endtask

  task automatic fire(input logic [PC_W-1:0] pc, input bit allowin);
    step(0, 0, 1, pc, 0, '0, allowin);
  endtask

  task automatic resp(input logic [DATA_W-1:0] d, input bit allowin);
    step(0, 0, 0, '0, 1, d, allowin);
  endtask

  initial begin
    bit r_rst, r_fl, r_fi, r_dk, r_al;
    @(negedge clk);

    // reset state
    step(1, 0, 0, '0, 0, '0, 0);
    step(1, 0, 0, '0, 0, '0, 0);
    idle(0);
    chk("rst_allow", req_allow_o, 1);
    chk("rst_valid", inst_valid_o, 0);
    chk("rst_pc", inst_pc_o, 0);
    chk("rst_data", inst_data_o, 0);

    // single fetch, response three cycles after the request
    fire(32'h1C00_0000, 1);
    idle(1);
    idle(1);
    resp(64'h0280_0C0C_0280_040C, 1);
    chk("t1_valid", inst_valid_o, 1);
    chk("t1_pc", inst_pc_o, 32'h1C00_0000);
    chk("t1_data", inst_data_o, 64'h0280_0C0C_0280_040C);
    idle(1);
    chk("t1_valid_once", inst_valid_o, 0);

    // fill to DEPTH
    for (int i = 0; i < DEPTH; i++) fire(32'h1C00_0100 + 32'(i * 4), 1);
    chk("t2_full", req_allow_o, 0);
    resp(64'h1111, 1);
    chk("t2_still_full", req_allow_o, 0);
    idle(1);
    chk("t2_allow_after_pop", req_allow_o, 1);
    for (int i = 0; i < DEPTH - 1; i++) resp(64'h2222 + 64'(i), 1);
    idle(1);

    // back-pressure, then in-order drain
    for (int i = 0; i < 3; i++) fire(32'h1C00_0200 + 32'(i * 8), 0);
    for (int i = 0; i < 3; i++) resp(64'hA000 + 64'(i), 0);
    for (int i = 0; i < 5; i++) begin
      idle(0);
      chk("t3_hold_pc", inst_pc_o, 32'h1C00_0200);
    end
    chk("t3_hold_valid", inst_valid_o, 1);
    idle(1);
    chk("t3_pc1", inst_pc_o, 32'h1C00_0208);
    idle(1);
    chk("t3_pc2", inst_pc_o, 32'h1C00_0210);
    idle(1);
    chk("t3_empty", inst_valid_o, 0);

    // flush with two responses outstanding
    for (int i = 0; i < 3; i++) fire(32'h1C00_0300 + 32'(i * 4), 0);
    resp(64'hB0, 0);
    step(0, 1, 0, '0, 0, '0, 1);
    chk("t4_valid", inst_valid_o, 0);
    chk("t4_disc", dut.u_ptr.discard_cnt, 2);
    resp(64'hDEAD, 1);
    resp(64'hBEEF, 1);
    chk("t4_dropped", inst_valid_o, 0);
    fire(32'h1C00_0800, 1);
    resp(64'hC0FFEE, 1);
    chk("t4_new_valid", inst_valid_o, 1);
    chk("t4_new_pc", inst_pc_o, 32'h1C00_0800);
    idle(1);

    // flush coincident with request and response
    fire(32'h1C00_0400, 1);
    step(0, 1, 1, 32'h1C00_0404, 1, 64'h55, 1);
    chk("t5_disc", dut.u_ptr.discard_cnt, 1);
    resp(64'h66, 1);
    chk("t5_no_out", inst_valid_o, 0);
    chk("t5_disc_done", dut.u_ptr.discard_cnt, 0);

    // reset mid-stream
    for (int i = 0; i < 3; i++) fire(32'h1C00_0500 + 32'(i * 4), 0);
    resp(64'h77, 0);
    step(1, 0, 0, '0, 0, '0, 0);
    chk("t6_valid", inst_valid_o, 0);
    chk("t6_pc", inst_pc_o, 0);
    chk("t6_data", inst_data_o, 0);
    chk("t6_allow", req_allow_o, 1);
    chk("t6_disc", dut.u_ptr.discard_cnt, 0);

    // random legal traffic
    for (int c = 0; c < 4000; c++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_fl  = !r_rst && ($urandom_range(0, 24) == 0);
      r_fi  = !r_rst && m_allow() && ($urandom_range(0, 1) == 1);
      r_dk  = !r_rst && ((m_disc > 0) || (m_unfilled() > 0)) && ($urandom_range(0, 2) != 0);
      r_al  = ($urandom_range(0, 3) != 0);
      step(r_rst, r_fl, r_fi, $urandom & 32'hFFFF_FFFC, r_dk, {$urandom, $urandom}, r_al);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
